interrupt_controller: RTL and testbench
=======================================

Name: interrupt_controller

Overview:
- Collects external interrupt lines, latches them as pending, applies per-line masks and a global enable, and picks the highest-priority request.
- Presents that request to the ControlUnit through a req/ack handshake with a stable vector address.
- Tracks in-service state until end-of-interrupt (EOI).
- Sits between the board-level `interrupt` pins and the ControlUnit's interrupt input, in the Operating_CLK domain produced by ClockDiv.

Parameters:
- NUM_IRQ, 2: number of interrupt lines. Index 0 is highest priority.
- VEC_BASE, 32'h0000_0100: vector address for line 0.
- VEC_STRIDE, 32'h0000_0010: address spacing between the vectors of consecutive lines.

Ports:
- Clock  in  1  operating clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- irq_in  in  NUM_IRQ  raw external requests; asynchronous, rising-edge triggered.
- global_en  in  1  CPU interrupt-enable bit.
- mask_wr  in  1  one-cycle pulse; loads mask_data.
- mask_data  in  NUM_IRQ  new mask value; 1 = line masked.
- int_ack  in  1  ControlUnit accepts the request (one-cycle pulse at an instruction boundary).
- eoi  in  1  ControlUnit signals return-from-interrupt (one-cycle pulse).
- int_req  out  1  request to the ControlUnit.
- int_id  out  $clog2(NUM_IRQ) (min 1)  selected line.
- vector  out  32  VEC_BASE + int_id*VEC_STRIDE.
- in_service  out  1  a handler is running.
- pending  out  NUM_IRQ  latched pending bits.
- mask  out  NUM_IRQ  current mask register.

Behaviour:
- Reset (async, active-low):
  - sync chains = 0; pending = 0; mask = all 1s (all masked).
  - state = IDLE; int_req = 0; int_id = 0; vector = VEC_BASE; in_service = 0.
  - Reset applies immediately, including mid-REQ or mid-SERVICE.
- Input path:
  - Each irq_in bit passes through a 2-FF synchronizer, then a rising-edge detect (sync2 & ~sync2_d).
  - A pin edge captured at clock k sets its pending bit at edge k+2.
  - A level held high produces only one pending set.
- Pending update priority, per bit:
  - A detected edge sets the bit.
  - int_ack clears the bit at int_id.
  - If set and clear land on the same bit in the same cycle, the set wins and the bit stays 1.
- Mask:
  - mask_wr loads mask_data on the next edge.
  - Masking never clears pending bits; it only hides them from arbitration.
- Eligibility: eligible = pending & ~mask, gated by global_en.
- FSM, 3 states, registered outputs:
  - IDLE: if eligible != 0, latch int_id = lowest set index of eligible, compute vector, set int_req = 1, go to REQ. Otherwise stay.
  - REQ:
    - int_id and vector stay frozen; a higher-priority arrival does not preempt.
    - On int_ack: clear pending[int_id], int_req = 0, in_service = 1, go to SERVICE.
    - If global_en drops or pending[int_id] & ~mask[int_id] drops before the ack: int_req = 0, go to IDLE, pending retained.
    - int_ack and a withdrawal condition in the same cycle: the ack wins.
  - SERVICE:
    - No nesting; int_req stays 0; new edges still set pending.
    - On eoi: in_service = 0, go to IDLE; re-arbitration happens on the following cycle.
- Ignored inputs:
  - int_ack outside REQ.
  - eoi outside SERVICE.
- Latency:
  - Pin edge to int_req = 4 edges: k+2 pending, k+3 int_req, provided the line is unmasked and global_en is high.
  - eoi to the next int_req = 2 edges when a request is pending.
- Vector arithmetic: 32-bit, wrap-around permitted; no overflow checks.

Decomposition:
- Shared package `intc_pkg`:
  - state enum IDLE / REQ / SERVICE;
  - default VEC_BASE and VEC_STRIDE constants;
  - function `prio_sel` returning the lowest set index.
- Sub-module `irq_sync_edge`:
  - one instance per line (generate loop);
  - 2-FF synchronizer plus edge detect;
  - ports: Clock, Reset, async_in, edge_pulse.

Test Plan:
1. Set mask = 2'b00, global_en = 1. Pulse irq_in[1] high.
   -> pending = 2'b10 at k+2; int_req = 1, int_id = 1, vector = 32'h110 at k+3.
   -> int_ack gives pending = 0, in_service = 1; eoi gives in_service = 0.
2. Raise irq_in = 2'b11 simultaneously.
   -> first int_id = 0, vector = 32'h100.
   -> after ack and eoi, a second int_req with int_id = 1 follows 2 cycles after eoi.
3. Set mask = 2'b01, then irq_in[0] edge.
   -> pending[0] = 1, int_req stays 0.
   -> mask_wr with 2'b00 gives int_req = 1 on the following cycle.
4. Drop global_en while in REQ with no ack.
   -> int_req falls the next cycle and pending is kept.
   -> restoring global_en re-raises int_req with the same int_id.
5. During SERVICE of line 1, edge on irq_in[0].
   -> pending[0] = 1, no int_req until eoi, then int_id = 0.
   -> also check: edge on the same bit in the ack cycle leaves pending set.
6. Assert Reset low mid-SERVICE with pending = 2'b11.
   -> all outputs return to reset values asynchronously (mask = 2'b11, vector = 32'h100).
   -> after release, no int_req until the mask is cleared and a new edge arrives.

Source files
------------

// File: rtl/intc_pkg.sv
// Shared types, default constants and the priority picker for the interrupt controller.
package intc_pkg;

    // FSM states of the request/service sequencer.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_e;

    // Default vector table placement: line 0 at the base, consecutive lines one stride apart.
    localparam logic [31:0] INTC_VEC_BASE_DEF   = 32'h0000_0100;
    localparam logic [31:0] INTC_VEC_STRIDE_DEF = 32'h0000_0010;

    // Widest request vector the priority picker handles.
    localparam int INTC_MAX_IRQ = 32;

    // Lowest set index of req (index 0 is the highest priority); 0 when req is empty.
    function automatic logic [4:0] prio_sel(input logic [INTC_MAX_IRQ-1:0] req);
        logic [4:0] idx;
        idx = '0;
        for (int i = INTC_MAX_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt pin followed by a rising-edge detector.
// A pin level first seen at clock k yields a one-cycle edge_pulse during the cycle after k+1.
module irq_sync_edge (
    input  logic Clock,
    input  logic Reset,
    input  logic async_in,
    output logic edge_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic sync2_dly_q, sync2_dly_d;

    // Next-state of the synchronizer chain and the delayed copy used for edge detection.
    always_comb begin
        sync1_d     = async_in;
        sync2_d     = sync1_q;
        sync2_dly_d = sync2_q;
    end

    // Synchronizer and delay flops; cleared asynchronously so a held pin re-triggers after reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync2_dly_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync2_dly_q <= sync2_dly_d;
        end
    end

    // A level held high produces exactly one pulse.
    assign edge_pulse = sync2_q & ~sync2_dly_q;

endmodule

// File: rtl/interrupt_controller.sv
// Interrupt controller: latches edges on the external lines as pending, masks and
// prioritises them, and hands the winner to the ControlUnit with a registered
// request, line id and vector address; tracks the handler until end-of-interrupt.
//
// Handshake: int_req rises with int_id/vector already valid and both stay frozen
// while int_req is high. The ControlUnit pulses int_ack for one cycle to take the
// request; int_req drops on that same edge and in_service rises. If the request
// becomes ineligible first (global_en low, or the line masked/no longer pending),
// int_req drops without an ack and the pending bit is kept. int_ack wins over a
// simultaneous withdrawal. eoi ends service; int_ack outside REQ and eoi outside
// SERVICE are ignored.
module interrupt_controller
    import intc_pkg::*;
#(
    parameter int          NUM_IRQ    = 2,
    parameter logic [31:0] VEC_BASE   = INTC_VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE = INTC_VEC_STRIDE_DEF,
    localparam int         ID_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               global_en,
    input  logic               mask_wr,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic [31:0]        vector,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask,
    output intc_state_e        state_dbg
);

    // ------------------------------------------------------------------
    // Input path: one synchronizer/edge detector per line
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0] edge_pulse;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync_edge u_sync (
            .Clock      (Clock),
            .Reset      (Reset),
            .async_in   (irq_in[g]),
            .edge_pulse (edge_pulse[g])
        );
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    intc_state_e        state_q, state_d;
    logic               int_req_q, int_req_d;
    logic [ID_W-1:0]    int_id_q, int_id_d;
    logic [31:0]        vector_q, vector_d;
    logic               in_service_q, in_service_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;

    // ------------------------------------------------------------------
    // Arbitration helpers
    // ------------------------------------------------------------------
    logic [NUM_IRQ-1:0]      id_onehot;
    logic [NUM_IRQ-1:0]      eligible;
    logic [INTC_MAX_IRQ-1:0] eligible_ext;
    logic                    sel_live;
    logic                    ack_take;
    logic [ID_W-1:0]         sel_id;
    logic [31:0]             sel_vec;

    // Decode the latched id, compute eligibility and the candidate id/vector for IDLE.
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            id_onehot[i] = (int_id_q == ID_W'(i));
        end
        eligible     = global_en ? (pending_q & ~mask_q) : '0;
        eligible_ext = INTC_MAX_IRQ'(eligible);
        // The frozen request is still valid only while its own line stays eligible.
        sel_live     = |(eligible & id_onehot);
        ack_take     = (state_q == ST_REQ) && int_ack;
        sel_id       = ID_W'(prio_sel(eligible_ext));
        sel_vec      = VEC_BASE + (VEC_STRIDE * 32'(sel_id));
    end

    // Pending and mask registers: a new edge beats a same-cycle ack clear on the same bit;
    // masking only hides lines from arbitration and never clears them.
    always_comb begin
        pending_d = (pending_q & ~(ack_take ? id_onehot : '0)) | edge_pulse;
        mask_d    = mask_wr ? mask_data : mask_q;
    end

    // Sequencer next-state and registered outputs.
    always_comb begin
        state_d      = state_q;
        int_req_d    = int_req_q;
        int_id_d     = int_id_q;
        vector_d     = vector_q;
        in_service_d = in_service_q;
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
                    int_id_d  = sel_id;
                    vector_d  = sel_vec;
                    int_req_d = 1'b1;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                // No preemption: id/vector stay as latched until ack or withdrawal.
                if (int_ack) begin
                    int_req_d    = 1'b0;
                    in_service_d = 1'b1;
                    state_d      = ST_SERVICE;
                end else if (!sel_live) begin
                    int_req_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                // No nesting; re-arbitration starts from IDLE on the cycle after eoi.
                if (eoi) begin
                    in_service_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                int_req_d    = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    // All controller state; reset takes effect immediately in any state.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= ST_IDLE;
            int_req_q    <= 1'b0;
            int_id_q     <= '0;
            vector_q     <= VEC_BASE;
            in_service_q <= 1'b0;
            pending_q    <= '0;
            mask_q       <= '1;
        end else begin
            state_q      <= state_d;
            int_req_q    <= int_req_d;
            int_id_q     <= int_id_d;
            vector_q     <= vector_d;
            in_service_q <= in_service_d;
            pending_q    <= pending_d;
            mask_q       <= mask_d;
        end
    end

    assign int_req    = int_req_q;
    assign int_id     = int_id_q;
    assign vector     = vector_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign mask       = mask_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a cycle-by-cycle vector table for the
// main flows, plus a hand-written asynchronous reset sequence.
module tb_interrupt_controller;
    import intc_pkg::*;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic        clk;
    logic        rst_n;
    logic [1:0]  irq_in;
    logic        global_en;
    logic        mask_wr;
    logic [1:0]  mask_data;
    logic        int_ack;
    logic        eoi;
    logic        int_req;
    logic [0:0]  int_id;
    logic [31:0] vector;
    logic        in_service;
    logic [1:0]  pending;
    logic [1:0]  mask;
    intc_state_e state_dbg;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    interrupt_controller #(
        .NUM_IRQ    (2),
        .VEC_BASE   (32'h0000_0100),
        .VEC_STRIDE (32'h0000_0010)
    ) dut (
        .Clock      (clk),
        .Reset      (rst_n),
        .irq_in     (irq_in),
        .global_en  (global_en),
        .mask_wr    (mask_wr),
        .mask_data  (mask_data),
        .int_ack    (int_ack),
        .eoi        (eoi),
        .int_req    (int_req),
        .int_id     (int_id),
        .vector     (vector),
        .in_service (in_service),
        .pending    (pending),
        .mask       (mask),
        .state_dbg  (state_dbg)
    );

    // ------------------------------------------------------------------
    // Vector record: inputs for one cycle and outputs expected after its edge
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0]  irq;
        logic        gen;
        logic        mwr;
        logic [1:0]  mdat;
        logic        ack;
        logic        eoi;
        logic        e_req;
        logic        e_id;
        logic        e_isv;
        logic [1:0]  e_pend;
        logic [1:0]  e_mask;
        logic [31:0] e_vec;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] irq, input logic gen, input logic mwr,
                                input logic [1:0] mdat, input logic ack, input logic eoi_i,
                                input logic e_req, input logic e_id, input logic e_isv,
                                input logic [1:0] e_pend, input logic [1:0] e_mask,
                                input logic [31:0] e_vec);
        vec_t v;
        v.irq = irq; v.gen = gen; v.mwr = mwr; v.mdat = mdat; v.ack = ack; v.eoi = eoi_i;
        v.e_req = e_req; v.e_id = e_id; v.e_isv = e_isv;
        v.e_pend = e_pend; v.e_mask = e_mask; v.e_vec = e_vec;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Scoreboard counters and compare
    // ------------------------------------------------------------------
    int n_checks;
    int n_fail;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, " int_req"},    32'(int_req),    32'(v.e_req));
        check({tag, " int_id"},     32'(int_id),     32'(v.e_id));
        check({tag, " in_service"}, 32'(in_service), 32'(v.e_isv));
        check({tag, " pending"},    32'(pending),    32'(v.e_pend));
        check({tag, " mask"},       32'(mask),       32'(v.e_mask));
        check({tag, " vector"},     vector,          v.e_vec);
    endtask

    // ------------------------------------------------------------------
    // Driver: apply one record for one cycle, check after the rising edge
    // ------------------------------------------------------------------
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        irq_in    = v.irq;
        global_en = v.gen;
        mask_wr   = v.mwr;
        mask_data = v.mdat;
        int_ack   = v.ack;
        eoi       = v.eoi;
        @(posedge clk);
        #1;
        check_outputs(tag, v);
    endtask

    vec_t tbl[$];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        irq_in    = 2'b00;
        global_en = 1'b0;
        mask_wr   = 1'b0;
        mask_data = 2'b00;
        int_ack   = 1'b0;
        eoi       = 1'b0;

        //              irq  gen mwr mdat ack eoi | req id isv pend  mask  vector
        // unmask everything
        tbl.push_back(mk(2'b00,1,1,2'b00,0,0, 0,0,0,2'b00,2'b00,32'h100)); // 0
        // 1: single edge on line 1
        tbl.push_back(mk(2'b10,1,0,2'b00,0,0, 0,0,0,2'b00,2'b00,32'h100)); // 1
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,0,0,2'b00,2'b00,32'h100)); // 2
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,0,0,2'b10,2'b00,32'h100)); // 3 pending k+2
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 1,1,0,2'b10,2'b00,32'h110)); // 4 int_req k+3
        tbl.push_back(mk(2'b00,1,0,2'b00,1,0, 0,1,1,2'b00,2'b00,32'h110)); // 5 ack
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,1,1,2'b00,2'b00,32'h110)); // 6
        tbl.push_back(mk(2'b00,1,0,2'b00,0,1, 0,1,0,2'b00,2'b00,32'h110)); // 7 eoi
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,1,0,2'b00,2'b00,32'h110)); // 8
        // 2: both lines together, held high (one set only)
        tbl.push_back(mk(2'b11,1,0,2'b00,0,0, 0,1,0,2'b00,2'b00,32'h110)); // 9
        tbl.push_back(mk(2'b11,1,0,2'b00,0,0, 0,1,0,2'b00,2'b00,32'h110)); // 10
        tbl.push_back(mk(2'b11,1,0,2'b00,0,0, 0,1,0,2'b11,2'b00,32'h110)); // 11
        tbl.push_back(mk(2'b11,1,0,2'b00,0,0, 1,0,0,2'b11,2'b00,32'h100)); // 12 line 0 wins
        tbl.push_back(mk(2'b11,1,0,2'b00,1,0, 0,0,1,2'b10,2'b00,32'h100)); // 13 ack
        tbl.push_back(mk(2'b11,1,0,2'b00,0,1, 0,0,0,2'b10,2'b00,32'h100)); // 14 eoi
        tbl.push_back(mk(2'b11,1,0,2'b00,0,0, 1,1,0,2'b10,2'b00,32'h110)); // 15 line 1 next
        tbl.push_back(mk(2'b11,1,0,2'b00,1,0, 0,1,1,2'b00,2'b00,32'h110)); // 16
        tbl.push_back(mk(2'b00,1,0,2'b00,0,1, 0,1,0,2'b00,2'b00,32'h110)); // 17
        // 3: masked line 0, then unmask
        tbl.push_back(mk(2'b00,1,1,2'b01,0,0, 0,1,0,2'b00,2'b01,32'h110)); // 18
        tbl.push_back(mk(2'b01,1,0,2'b00,0,0, 0,1,0,2'b00,2'b01,32'h110)); // 19
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,1,0,2'b00,2'b01,32'h110)); // 20
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,1,0,2'b01,2'b01,32'h110)); // 21
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,1,0,2'b01,2'b01,32'h110)); // 22 still masked
        tbl.push_back(mk(2'b00,1,1,2'b00,0,0, 0,1,0,2'b01,2'b00,32'h110)); // 23 unmask
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 1,0,0,2'b01,2'b00,32'h100)); // 24
        // 4: withdraw via global_en; stray ack in IDLE and eoi in REQ ignored
        tbl.push_back(mk(2'b00,0,0,2'b00,0,0, 0,0,0,2'b01,2'b00,32'h100)); // 25
        tbl.push_back(mk(2'b00,0,0,2'b00,1,0, 0,0,0,2'b01,2'b00,32'h100)); // 26 ack in IDLE
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 1,0,0,2'b01,2'b00,32'h100)); // 27 re-raised
        tbl.push_back(mk(2'b00,1,0,2'b00,0,1, 1,0,0,2'b01,2'b00,32'h100)); // 28 eoi in REQ
        tbl.push_back(mk(2'b00,1,0,2'b00,1,0, 0,0,1,2'b00,2'b00,32'h100)); // 29
        tbl.push_back(mk(2'b00,1,0,2'b00,0,1, 0,0,0,2'b00,2'b00,32'h100)); // 30
        // 5: line 0 arrives while line 1 is in service
        tbl.push_back(mk(2'b10,1,0,2'b00,0,0, 0,0,0,2'b00,2'b00,32'h100)); // 31
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,0,0,2'b00,2'b00,32'h100)); // 32
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,0,0,2'b10,2'b00,32'h100)); // 33
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 1,1,0,2'b10,2'b00,32'h110)); // 34
        tbl.push_back(mk(2'b00,1,0,2'b00,1,0, 0,1,1,2'b00,2'b00,32'h110)); // 35
        tbl.push_back(mk(2'b01,1,0,2'b00,0,0, 0,1,1,2'b00,2'b00,32'h110)); // 36
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,1,1,2'b00,2'b00,32'h110)); // 37
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,1,1,2'b01,2'b00,32'h110)); // 38 no nesting
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,1,1,2'b01,2'b00,32'h110)); // 39
        tbl.push_back(mk(2'b00,1,0,2'b00,0,1, 0,1,0,2'b01,2'b00,32'h110)); // 40 eoi
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 1,0,0,2'b01,2'b00,32'h100)); // 41
        // 5b: edge on the same bit in the ack cycle keeps pending set
        tbl.push_back(mk(2'b01,1,0,2'b00,0,0, 1,0,0,2'b01,2'b00,32'h100)); // 42
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 1,0,0,2'b01,2'b00,32'h100)); // 43
        tbl.push_back(mk(2'b00,1,0,2'b00,1,0, 0,0,1,2'b01,2'b00,32'h100)); // 44 set wins
        tbl.push_back(mk(2'b00,1,0,2'b00,0,1, 0,0,0,2'b01,2'b00,32'h100)); // 45
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 1,0,0,2'b01,2'b00,32'h100)); // 46
        // into SERVICE with both lines pending, ready for reset
        tbl.push_back(mk(2'b00,1,0,2'b00,1,0, 0,0,1,2'b00,2'b00,32'h100)); // 47
        tbl.push_back(mk(2'b11,1,0,2'b00,0,0, 0,0,1,2'b00,2'b00,32'h100)); // 48
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,0,1,2'b00,2'b00,32'h100)); // 49
        tbl.push_back(mk(2'b00,1,0,2'b00,0,0, 0,0,1,2'b11,2'b00,32'h100)); // 50

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", mk(2'b00,0,0,2'b00,0,0, 0,0,0,2'b00,2'b11,32'h100));
        check("reset state", 32'(state_dbg), 32'(ST_IDLE));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("row%0d", i), tbl[i]);
        end
        check("pre-reset state", 32'(state_dbg), 32'(ST_SERVICE));

        // 6: asynchronous reset mid-SERVICE, checked before any clock edge
        @(negedge clk);
        rst_n   = 1'b0;
        irq_in  = 2'b00;
        int_ack = 1'b0;
        eoi     = 1'b0;
        #1;
        check_outputs("async_rst", mk(2'b00,1,0,2'b00,0,0, 0,0,0,2'b00,2'b11,32'h100));
        check("async_rst state", 32'(state_dbg), 32'(ST_IDLE));
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // After release: a new edge is pending but masked until the mask is cleared.
        step("post0", mk(2'b00,1,0,2'b00,0,0, 0,0,0,2'b00,2'b11,32'h100));
        step("post1", mk(2'b01,1,0,2'b00,0,0, 0,0,0,2'b00,2'b11,32'h100));
        step("post2", mk(2'b00,1,0,2'b00,0,0, 0,0,0,2'b00,2'b11,32'h100));
        step("post3", mk(2'b00,1,0,2'b00,0,0, 0,0,0,2'b01,2'b11,32'h100));
        step("post4", mk(2'b00,1,0,2'b00,0,0, 0,0,0,2'b01,2'b11,32'h100));
        step("post5", mk(2'b00,1,1,2'b00,0,0, 0,0,0,2'b01,2'b00,32'h100));
        step("post6", mk(2'b00,1,0,2'b00,0,0, 1,0,0,2'b01,2'b00,32'h100));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
